// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM path: bus widths, default timing/base constants,
// controller state encoding and the CPU-address to SRAM-location mapping.
package arm_mem_pkg;

  localparam int unsigned SRAM_ADDR_W   = 17;
  localparam int unsigned SRAM_DATA_W   = 64;
  localparam int unsigned CPU_DATA_W    = 32;
  localparam int unsigned DEF_SRAM_WAIT = 5;
  localparam int unsigned DEF_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] word;
    logic                   half;
  } sram_loc_t;

  // Bits above the 1 MB window and the byte offset are dropped; the region simply wraps.
  function automatic sram_loc_t map_addr(input logic [31:0] address, input logic [31:0] base);
    logic [19:2] phys;
    sram_loc_t   loc;
    phys     = 18'((address - base) >> 2);
    loc.word = phys[19:3];
    loc.half = phys[2];
    return loc;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer for SRAM accesses: loadable down-counter that saturates at zero.
// Zero flag is registered state, so a phase loaded with N-1 lasts exactly N cycles.
module sram_wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM initiator: loads take SRAM_WAIT+1 cycles, stores (read-modify-write) 2*SRAM_WAIT+1.
// `ready` drops combinationally the cycle a request is seen and rises only in the DONE cycle.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = DEF_SRAM_WAIT,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N
);

  localparam int unsigned  CW      = $clog2(SRAM_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(SRAM_WAIT - 1);

  mem_state_t state_q;
  mem_state_t state_d;

  logic                   req;
  logic                   accept;
  sram_loc_t              loc;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic                   half_q;
  logic [CPU_DATA_W-1:0]  wdata_q;
  logic                   is_wr_q;
  logic [SRAM_DATA_W-1:0] buf_q;
  logic [CPU_DATA_W-1:0]  rdata_q;
  logic [SRAM_DATA_W-1:0] wr_word;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic capture;

  assign req    = rd_en | wr_en;
  assign accept = (state_q == ST_IDLE) && req;
  assign loc    = map_addr(address, 32'(BASE_ADDR));

  sram_wait_counter #(
    .W(CW)
  ) u_wait (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(WAIT_LD),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req) state_d = ST_RD;
      ST_RD:   if (cnt_zero) state_d = is_wr_q ? ST_WR : ST_DONE;
      ST_WR:   if (cnt_zero) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready    = !req;
        cnt_load = req;
      end
      ST_RD: begin
        cnt_dec  = 1'b1;
        capture  = cnt_zero;
        cnt_load = cnt_zero && is_wr_q;
      end
      ST_WR: begin
        SRAM_WE_N = 1'b0;
        cnt_dec   = 1'b1;
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
    // The pipeline must not stall on a controller that is being held in reset.
    if (!rst) ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= loc.word;
        half_q  <= loc.half;
        wdata_q <= wdata;
        is_wr_q <= wr_en;
      end
      if (capture) begin
        buf_q <= SRAM_DQ;
        // Loaded straight from the bus so rdata is already valid in the DONE cycle.
        if (!is_wr_q) begin
          rdata_q <= half_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
        end
      end
    end
  end

  assign wr_word   = half_q ? {wdata_q, buf_q[31:0]} : {buf_q[63:32], wdata_q};
  assign SRAM_DQ   = (state_q == ST_WR) ? wr_word : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM bus model, directed vector table, multi-cycle corner sequences
// and randomized traffic checked against a 32-bit-word reference memory.
module tb_sram_controller;
  import arm_mem_pkg::*;

  localparam int unsigned WAIT   = 5;
  localparam logic [31:0] BASE   = 32'd1024;
  localparam int unsigned NWORDS = 1 << SRAM_ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  wire  [63:0] sram_dq;
  logic [16:0] sram_addr;
  logic        sram_we_n;

  always #5 clk = ~clk;

  sram_controller #(
    .SRAM_WAIT(WAIT),
    .BASE_ADDR(1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .SRAM_DQ  (sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n)
  );

  function automatic logic [31:0] init32(input logic [31:0] k);
    return k[0] ? (32'hA500_0000 ^ k) : (32'h5A00_0000 ^ k);
  endfunction

  // SRAM model: drives the bus whenever WE_N is high; a write only lands after a full-length
  // WE_N pulse, so an interrupted write leaves the array untouched.
  logic [63:0] mem [NWORDS];
  bit          mem_loaded = 1'b0;
  int          wcnt = 0;

  assign sram_dq = sram_we_n ? mem[sram_addr] : 64'bz;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem[i] = {init32(32'(2 * i + 1)), init32(32'(2 * i))};
      end
      mem_loaded = 1'b1;
    end
    if (!sram_we_n) begin
      if (wcnt == WAIT - 1) mem[sram_addr] = sram_dq;
      wcnt = wcnt + 1;
    end else begin
      wcnt = 0;
    end
  end

  // Reference: flat memory of 32-bit words indexed by (address - BASE) / 4 within a 1 MB window.
  logic [31:0] ref_mem [int unsigned];

  function automatic int unsigned cpu_key(input logic [31:0] a);
    logic [31:0] p;
    p = (a - BASE) % 32'h0010_0000;
    return int'(p / 4);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned k);
    if (ref_mem.exists(k)) return ref_mem[k];
    return init32(32'(k));
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic run_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int welow, output logic [31:0] rd_o,
                         output logic [16:0] sa_o, output bit ok);
    lat = 0; welow = 0; ok = 1'b0;
    @(negedge clk);
    rd_en = r; wr_en = w; address = a; wdata = d;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ready) begin
        ok = 1'b1;
        break;
      end
      lat++;
      if (!sram_we_n) welow++;
      @(negedge clk);
    end
    rd_o = rdata;
    sa_o = sram_addr;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_check(input string nm, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input int exp_welow,
                          input logic [31:0] exp_rd, input logic [16:0] exp_sa);
    int lat, welow;
    logic [31:0] got_rd;
    logic [16:0] got_sa;
    bit ok;
    run_txn(r, w, a, d, lat, welow, got_rd, got_sa, ok);
    chk({nm, " completes"}, 64'(ok), 64'(1));
    chk({nm, " ready-low cycles"}, 64'(lat), 64'(exp_lat));
    chk({nm, " WE_N-low cycles"}, 64'(welow), 64'(exp_welow));
    chk({nm, " rdata"}, 64'(got_rd), 64'(exp_rd));
    chk({nm, " SRAM_ADDR"}, 64'(got_sa), 64'(exp_sa));
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_welow;
    logic [16:0] exp_sa;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] last_load;
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp [3];
  logic [63:0] pre_word;
  logic        r, w;
  logic [31:0] a, d, e;
  int unsigned k;
  int          idx, cycles, wl, nready;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1024,        32'hDEAD_BEEF, 32'h0,         11, 5, 17'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024,        32'h0,         32'hDEAD_BEEF,  6, 0, 17'd0};
    vecs[2] = '{1'b0, 1'b1, 32'd1024,        32'h1111_1111, 32'h0,         11, 5, 17'd0};
    vecs[3] = '{1'b0, 1'b1, 32'd1028,        32'h2222_2222, 32'h0,         11, 5, 17'd0};
    vecs[4] = '{1'b1, 1'b0, 32'd1024,        32'h0,         32'h1111_1111,  6, 0, 17'd0};
    vecs[5] = '{1'b1, 1'b0, 32'd1028,        32'h0,         32'h2222_2222,  6, 0, 17'd0};
    vecs[6] = '{1'b1, 1'b0, 32'h0010_0400,   32'h0,         32'h1111_1111,  6, 0, 17'd0};
    vecs[7] = '{1'b1, 1'b0, 32'd1026,        32'h0,         32'h1111_1111,  6, 0, 17'd0};
    vecs[8] = '{1'b1, 1'b1, 32'd1032,        32'hCAFE_F00D, 32'h0,         11, 5, 17'd1};
    vecs[9] = '{1'b1, 1'b0, 32'd1032,        32'h0,         32'hCAFE_F00D,  6, 0, 17'd1};

    // Reset state, with a request already pending from the pipeline.
    rd_en = 1'b1;
    address = 32'd2048;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'(1));
    chk("reset WE_N", 64'(sram_we_n), 64'(1));
    chk("reset SRAM_ADDR", 64'(sram_addr), 64'(0));
    chk("reset rdata", 64'(rdata), 64'(0));
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_load = '0;

    for (int i = 0; i < 10; i++) begin
      logic is_ld;
      is_ld = vecs[i].rd && !vecs[i].wr;
      do_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_lat, vecs[i].exp_welow, is_ld ? vecs[i].exp_rdata : last_load,
               vecs[i].exp_sa);
      if (is_ld) last_load = vecs[i].exp_rdata;
      if (vecs[i].wr) ref_mem[cpu_key(vecs[i].addr)] = vecs[i].wdata;
    end
    chk("word0 after RMW pair", mem[0], 64'h2222_2222_1111_1111);
    chk("word1 upper half kept", mem[1], {init32(32'd3), 32'hCAFE_F00D});

    // Three loads held back-to-back by the pipeline.
    b2b_addr[0] = 32'd1024; b2b_addr[1] = 32'd1028; b2b_addr[2] = 32'd1032;
    for (int i = 0; i < 3; i++) b2b_exp[i] = ref_rd(cpu_key(b2b_addr[i]));
    idx = 0; cycles = 0; wl = 0; nready = 0;
    @(negedge clk);
    rd_en = 1'b1;
    address = b2b_addr[0];
    for (int c = 0; c < 200 && idx < 3; c++) begin
      #1;
      cycles++;
      if (!sram_we_n) wl++;
      if (ready) begin
        nready++;
        chk($sformatf("b2b load%0d rdata", idx), 64'(rdata), 64'(b2b_exp[idx]));
        idx++;
        if (idx < 3) address = b2b_addr[idx];
        else rd_en = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b completions", 64'(idx), 64'(3));
    chk("b2b total cycles", 64'(cycles), 64'(21));
    chk("b2b ready cycles", 64'(nready), 64'(3));
    chk("b2b WE_N low", 64'(wl), 64'(0));
    last_load = b2b_exp[2];

    // Reset in the second cycle of the write phase.
    pre_word = mem[2];
    wl = 0;
    wr_en = 1'b1;
    address = 32'd1040;
    wdata = 32'h1234_5678;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!sram_we_n) wl++;
      if (wl == 2) break;
      @(negedge clk);
    end
    chk("midWR reached", 64'(wl), 64'(2));
    rst = 1'b0;
    #1;
    chk("midWR rst WE_N", 64'(sram_we_n), 64'(1));
    chk("midWR rst ready", 64'(ready), 64'(1));
    chk("midWR rst SRAM_ADDR", 64'(sram_addr), 64'(0));
    chk("midWR rst rdata", 64'(rdata), 64'(0));
    chk("midWR rst DQ released", sram_dq, mem[0]);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("midWR word unchanged", mem[2], pre_word);
    do_check("midWR reload", 1'b1, 1'b0, 32'd1040, 32'h0, 6, 0, ref_rd(cpu_key(32'd1040)), 17'd2);
    last_load = ref_rd(cpu_key(32'd1040));

    // Randomized loads/stores across the window, its aliases and arbitrary addresses.
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      a = BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = a + 32'h0010_0000 * 32'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      d = $urandom;
      k = cpu_key(a);
      e = (r && !w) ? ref_rd(k) : last_load;
      do_check($sformatf("rand%0d", t), r, w, a, d, w ? 2 * WAIT + 1 : WAIT + 1, w ? WAIT : 0,
               e, 17'(k / 2));
      if (r && !w) last_load = e;
      if (w) ref_mem[k] = d;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
